// File: rtl/pwm_device_pkg.sv
// Register map, CONFIG bit positions and a byte-lane merge helper shared by
// the PWM peripheral and anything that needs to address it.
`timescale 1ns/1ps
package pwm_device_pkg;

    localparam logic [4:0] ADDR_CONFIG       = 5'h00;
    localparam logic [4:0] ADDR_TOP          = 5'h04;
    localparam logic [4:0] ADDR_COUNTER      = 5'h08;
    localparam logic [4:0] ADDR_COMPARE_BASE = 5'h10;

    localparam int CFG_ENABLE    = 0;
    localparam int CFG_SCALE_LSB = 1;
    localparam int CFG_SCALE_W   = 3;
    localparam int CFG_IRQ_EN    = 4;
    localparam int CFG_IRQ_FLAG  = 5;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        byte_merge = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) byte_merge[8*b +: 8] = new_v[8*b +: 8];
        end
    endfunction

endpackage

// File: rtl/pwm_device_prescaler.sv
// Clock prescaler: one-cycle tick every 2^scale_i clocks while enabled.
`timescale 1ns/1ps
module pwm_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic [2:0] scale_i,
    input  logic       restart_i,
    output logic       tick_o
);

    logic [6:0] count_q, count_d;
    logic [6:0] mask;

    // Low scale_i bits set: the terminal count for a 2^scale_i divide.
    assign mask   = ~(7'h7F << scale_i);
    assign tick_o = enable_i & (count_q == mask);

    always_comb begin
        count_d = count_q + 7'd1;
        if (!enable_i || restart_i || tick_o) count_d = 7'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= 7'd0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/pwm_device.sv
// Memory-mapped PWM generator: prescaled up-counter, double-buffered top and
// compare values loaded at wrap, registered outputs and a wrap interrupt.
`timescale 1ns/1ps
module pwm_device
    import pwm_device_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OUTPUTS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               peripheralBus_we,
    input  logic               peripheralBus_oe,
    input  logic [4:0]         peripheralBus_address,
    input  logic [3:0]         peripheralBus_byteSelect,
    input  logic [31:0]        peripheralBus_dataWrite,
    output logic [31:0]        peripheralBus_dataRead,
    output logic               peripheralBus_busy,
    output logic [OUTPUTS-1:0] pwm_out,
    output logic               pwm_irq
);

    logic               enable_q, enable_d;
    logic [2:0]         scale_q, scale_d;
    logic               irq_en_q, irq_en_d;
    logic               irq_flag_q, irq_flag_d;
    logic [WIDTH-1:0]   top_sh_q, top_sh_d, top_act_q, top_act_d;
    logic [WIDTH-1:0]   cmp_sh_q [OUTPUTS];
    logic [WIDTH-1:0]   cmp_sh_d [OUTPUTS];
    logic [WIDTH-1:0]   cmp_act_q [OUTPUTS];
    logic [WIDTH-1:0]   cmp_act_d [OUTPUTS];
    logic [WIDTH-1:0]   counter_q, counter_d;
    logic [OUTPUTS-1:0] pwm_q, pwm_d;
    logic [31:0]        data_read_q, data_read_d;

    logic [2:0]  word;
    logic [1:0]  cmp_idx;
    logic        sel_config, sel_top, sel_counter, sel_cmp;
    logic        cfg_wr, tick, wrap, restart;
    logic [31:0] rd_data, wr_merged;
    logic        unused_addr;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        zext = '0;
        zext[WIDTH-1:0] = v;
    endfunction

    assign word        = peripheralBus_address[4:2];
    assign cmp_idx     = peripheralBus_address[3:2];
    assign sel_config  = (word == ADDR_CONFIG[4:2]);
    assign sel_top     = (word == ADDR_TOP[4:2]);
    assign sel_counter = (word == ADDR_COUNTER[4:2]);
    assign sel_cmp     = (word >= ADDR_COMPARE_BASE[4:2]) && (int'(cmp_idx) < OUTPUTS);
    assign unused_addr = &{1'b0, peripheralBus_address[1:0]};

    assign cfg_wr  = peripheralBus_we & sel_config & peripheralBus_byteSelect[0];
    assign restart = cfg_wr;
    assign wrap    = tick & (counter_q == top_act_q);

    pwm_prescaler u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_i  (enable_q),
        .scale_i   (scale_q),
        .restart_i (restart),
        .tick_o    (tick)
    );

    // Current value of the addressed register, also the base for byte-lane merges.
    always_comb begin
        rd_data = '0;
        if (sel_config) begin
            rd_data[CFG_ENABLE]                   = enable_q;
            rd_data[CFG_SCALE_LSB +: CFG_SCALE_W] = scale_q;
            rd_data[CFG_IRQ_EN]                   = irq_en_q;
            rd_data[CFG_IRQ_FLAG]                 = irq_flag_q;
        end else if (sel_top) begin
            rd_data = zext(top_sh_q);
        end else if (sel_counter) begin
            rd_data = zext(counter_q);
        end else if (sel_cmp) begin
            rd_data = zext(cmp_sh_q[cmp_idx]);
        end
    end

    assign wr_merged = byte_merge(rd_data, peripheralBus_dataWrite, peripheralBus_byteSelect);

    always_comb begin
        enable_d   = enable_q;
        scale_d    = scale_q;
        irq_en_d   = irq_en_q;
        irq_flag_d = irq_flag_q;
        top_sh_d   = top_sh_q;
        if (cfg_wr) begin
            enable_d = peripheralBus_dataWrite[CFG_ENABLE];
            scale_d  = peripheralBus_dataWrite[CFG_SCALE_LSB +: CFG_SCALE_W];
            irq_en_d = peripheralBus_dataWrite[CFG_IRQ_EN];
            if (peripheralBus_dataWrite[CFG_IRQ_FLAG]) irq_flag_d = 1'b0;
        end
        // A wrap in the same cycle as a clear keeps the flag set.
        if (wrap) irq_flag_d = 1'b1;
        if (peripheralBus_we && sel_top) top_sh_d = wr_merged[WIDTH-1:0];
        for (int i = 0; i < OUTPUTS; i++) begin
            cmp_sh_d[i] = cmp_sh_q[i];
            if (peripheralBus_we && sel_cmp && int'(cmp_idx) == i)
                cmp_sh_d[i] = wr_merged[WIDTH-1:0];
        end
    end

    // Active values follow the shadows while idle and reload only at wrap.
    always_comb begin
        counter_d = counter_q;
        top_act_d = top_act_q;
        for (int i = 0; i < OUTPUTS; i++) cmp_act_d[i] = cmp_act_q[i];
        if (!enable_q || wrap) begin
            counter_d = '0;
            top_act_d = top_sh_q;
            for (int i = 0; i < OUTPUTS; i++) cmp_act_d[i] = cmp_sh_q[i];
        end else if (tick) begin
            counter_d = counter_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        for (int i = 0; i < OUTPUTS; i++) pwm_d[i] = enable_q & (counter_q >= cmp_act_q[i]);
        data_read_d = peripheralBus_oe ? rd_data : data_read_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q    <= 1'b0;
            scale_q     <= 3'd0;
            irq_en_q    <= 1'b0;
            irq_flag_q  <= 1'b0;
            top_sh_q    <= '0;
            top_act_q   <= '0;
            counter_q   <= '0;
            pwm_q       <= '0;
            data_read_q <= '0;
            for (int i = 0; i < OUTPUTS; i++) begin
                cmp_sh_q[i]  <= '0;
                cmp_act_q[i] <= '0;
            end
        end else begin
            enable_q    <= enable_d;
            scale_q     <= scale_d;
            irq_en_q    <= irq_en_d;
            irq_flag_q  <= irq_flag_d;
            top_sh_q    <= top_sh_d;
            top_act_q   <= top_act_d;
            counter_q   <= counter_d;
            pwm_q       <= pwm_d;
            data_read_q <= data_read_d;
            for (int i = 0; i < OUTPUTS; i++) begin
                cmp_sh_q[i]  <= cmp_sh_d[i];
                cmp_act_q[i] <= cmp_act_d[i];
            end
        end
    end

    assign peripheralBus_dataRead = data_read_q;
    assign peripheralBus_busy     = 1'b0;
    assign pwm_out                = pwm_q;
    assign pwm_irq                = irq_flag_q & irq_en_q;

endmodule

// File: tb/tb_pwm_device.sv
// Self-checking bench for pwm_device: register table, randomized waveforms
// against an arithmetic period model, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_pwm_device;
  import pwm_device_pkg::*;

  localparam int WIDTH   = 16;
  localparam int OUTPUTS = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               we = 1'b0, oe = 1'b0;
  logic [4:0]         addr = '0;
  logic [3:0]         be = '0;
  logic [31:0]        wdata = '0;
  logic [31:0]        rdata;
  logic               busy;
  logic [OUTPUTS-1:0] pwm_out;
  logic               pwm_irq;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  pwm_device #(.WIDTH(WIDTH), .OUTPUTS(OUTPUTS)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .peripheralBus_we         (we),
    .peripheralBus_oe         (oe),
    .peripheralBus_address    (addr),
    .peripheralBus_byteSelect (be),
    .peripheralBus_dataWrite  (wdata),
    .peripheralBus_dataRead   (rdata),
    .peripheralBus_busy       (busy),
    .pwm_out                  (pwm_out),
    .pwm_irq                  (pwm_irq)
  );

  // ---------------- clock / reset ----------------
  always #12.5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
    @(posedge clk); #1;
    we = 1'b1; addr = a; be = b; wdata = d;
    @(posedge clk); #1;
    we = 1'b0; be = '0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    oe = 1'b1; addr = a;
    @(posedge clk); #1;
    oe = 1'b0;
    d = rdata;
  endtask

  // Program shadows then enable; returns the cycle stamp of the enabling edge.
  task automatic start_pwm(input int s, input int top, input int c0, input int c1,
                           input int c2, input int c3, input bit irq_en, output int t0);
    bus_write(ADDR_TOP, 4'hF, top);
    bus_write(ADDR_COMPARE_BASE + 5'd0, 4'hF, c0);
    bus_write(ADDR_COMPARE_BASE + 5'd4, 4'hF, c1);
    bus_write(ADDR_COMPARE_BASE + 5'd8, 4'hF, c2);
    bus_write(ADDR_COMPARE_BASE + 5'd12, 4'hF, c3);
    bus_write(ADDR_CONFIG, 4'hF, 32'(1 | (s << 1) | (int'(irq_en) << 4)));
    t0 = cyc;
  endtask

  task automatic stop_pwm(input string tag);
    bus_write(ADDR_CONFIG, 4'hF, 32'h0);
    bus_write(ADDR_CONFIG, 4'hF, 32'h20);
    @(negedge clk);
    check({tag, "_stop_pwm"}, 32'(pwm_out), 32'h0);
    check({tag, "_stop_irq"}, 32'(pwm_irq), 32'h0);
  endtask

  // ---------------- reference model ----------------
  // j = clocks since the enabling edge. Each counter value lasts 2^s clocks,
  // the output lags the counter by one clock and is low for counter < compare.
  function automatic bit model_pwm(int j, int s, int top, int cmp);
    int p = 1 << s;
    if (j < 1) return 1'b0;
    return (((j - 1) / p) % (top + 1)) >= cmp;
  endfunction

  function automatic bit model_irq(int j, int s, int top, bit irq_en);
    return irq_en && (j >= (top + 1) * (1 << s));
  endfunction

  // ---------------- register table ----------------
  typedef struct {
    logic [4:0]  a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];

  initial begin
    logic [31:0] rd;
    int t0;
    int cmp[4];
    int s, top;
    bit ie;
    int edges[$];
    int bad1, bad3;
    logic prev;

    vecs[0]  = '{5'h04, 4'hF, 32'hDEADBEEF, 32'h0000BEEF};
    vecs[1]  = '{5'h04, 4'h2, 32'h00001200, 32'h000012EF};
    vecs[2]  = '{5'h04, 4'h4, 32'h00FF0000, 32'h000012EF};
    vecs[3]  = '{5'h14, 4'hF, 32'h0000ABCD, 32'h0000ABCD};
    vecs[4]  = '{5'h1C, 4'h1, 32'h12345655, 32'h00000055};
    vecs[5]  = '{5'h18, 4'h3, 32'hFFFF5A5A, 32'h00005A5A};
    vecs[6]  = '{5'h0C, 4'hF, 32'hFFFFFFFF, 32'h00000000};
    vecs[7]  = '{5'h08, 4'hF, 32'h12345678, 32'h00000000};
    vecs[8]  = '{5'h00, 4'hF, 32'h0000001E, 32'h0000001E};
    vecs[9]  = '{5'h00, 4'h2, 32'h000000FF, 32'h0000001E};
    vecs[10] = '{5'h00, 4'hF, 32'h00000000, 32'h00000000};

    // Reset state
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("reset_pwm", 32'(pwm_out), 32'h0);
    check("reset_irq", 32'(pwm_irq), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("busy", 32'(busy), 32'h0);
    foreach (exp_q[i]) exp_q.delete();
    for (int a = 0; a < 32; a += 4) begin
      bus_read(5'(a), rd);
      check($sformatf("reset_reg_%0h", a), rd, 32'h0);
    end

    // Register table: write, then read back the same address
    foreach (vecs[i]) begin
      bus_write(vecs[i].a, vecs[i].b, vecs[i].d);
      bus_read(vecs[i].a, rd);
      check($sformatf("regtab_%0d", i), rd, vecs[i].exp);
    end

    // Randomized waveforms against the model
    for (int trial = 0; trial < 8; trial++) begin
      s   = $urandom_range(0, 3);
      top = $urandom_range(0, 15);
      for (int i = 0; i < 4; i++) cmp[i] = $urandom_range(0, top + 2);
      ie  = 1'($urandom_range(0, 1));
      start_pwm(s, top, cmp[0], cmp[1], cmp[2], cmp[3], ie, t0);
      for (int j = 0; j < 2 * (top + 1) * (1 << s) + 10; j++) begin
        logic [31:0] e;
        e = '0;
        for (int i = 0; i < 4; i++) e[i] = model_pwm(j, s, top, cmp[i]);
        e[8] = model_irq(j, s, top, ie);
        exp_q.push_back(e);
      end
      for (int j = 0; exp_q.size() > 0; j++) begin
        logic [31:0] e;
        @(negedge clk);
        e = exp_q.pop_front();
        check($sformatf("rand%0d_pwm_j%0d", trial, cyc - t0), 32'(pwm_out), {28'h0, e[3:0]});
        check($sformatf("rand%0d_irq_j%0d", trial, cyc - t0), 32'(pwm_irq), {31'h0, e[8]});
      end
      stop_pwm($sformatf("rand%0d", trial));
    end

    // Timing with extremes: ch2 low = 25*8, period = 50*8; ch1 always high, ch3 always low
    start_pwm(3, 49, 0, 0, 25, 50, 1'b0, t0);
    bad1 = 0; bad3 = 0;
    @(negedge clk);
    prev = pwm_out[2];
    for (int k = 0; k < 820; k++) begin
      @(negedge clk);
      if (pwm_out[2] != prev) edges.push_back(cyc - t0);
      prev = pwm_out[2];
      if (pwm_out[1] !== 1'b1) bad1++;
      if (pwm_out[3] !== 1'b0) bad3++;
    end
    check("timing_edge_count", 32'(edges.size()), 32'd4);
    while (edges.size() < 4) edges.push_back(-1);
    check("timing_rise0", 32'(edges[0]), 32'd201);
    check("timing_fall0", 32'(edges[1]), 32'd401);
    check("timing_low",   32'(edges[2] - edges[1]), 32'd200);
    check("timing_period", 32'(edges[3] - edges[1]), 32'd400);
    check("cmp0_always_high", 32'(bad1), 32'd0);
    check("cmp_gt_top_always_low", 32'(bad3), 32'd0);
    stop_pwm("timing");

    // Double buffering: shrink TOP mid-period below the current count
    begin
      int tf1, tr, tf2;
      int budget = 100;
      start_pwm(0, 19, 5, 0, 0, 0, 1'b0, t0);
      repeat (8) @(posedge clk);
      bus_write(ADDR_TOP, 4'hF, 32'd7);
      tf1 = -1; tr = -1; tf2 = -1;
      @(negedge clk);
      prev = pwm_out[0];
      for (int k = 0; k < budget && tf2 < 0; k++) begin
        @(negedge clk);
        if (prev && !pwm_out[0]) begin
          if (tf1 < 0) tf1 = cyc - t0; else tf2 = cyc - t0;
        end
        if (!prev && pwm_out[0] && tf1 >= 0 && tr < 0) tr = cyc - t0;
        prev = pwm_out[0];
      end
      if (tf2 < 0) begin
        n_checks++; n_errors++;
        $display("FAIL dbuf_timeout: got no second falling edge required one within %0d cycles", budget);
      end
      check("dbuf_first_fall", 32'(tf1), 32'd21);
      check("dbuf_rise", 32'(tr), 32'd26);
      check("dbuf_second_fall", 32'(tf2), 32'd29);
      stop_pwm("dbuf");
    end

    // COUNTER read returns the oe-cycle value
    start_pwm(0, 1000, 0, 0, 0, 0, 1'b0, t0);
    bus_read(ADDR_COUNTER, rd);
    check("counter_read0", rd, 32'd1);
    bus_read(ADDR_COUNTER, rd);
    check("counter_read1", rd, 32'd3);
    stop_pwm("counter");

    // Clearing the flag in a wrap cycle: set wins (TOP=0 wraps every clock)
    start_pwm(0, 0, 0, 0, 0, 0, 1'b1, t0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("irq_raised", 32'(pwm_irq), 32'h1);
    bus_write(ADDR_CONFIG, 4'hF, 32'h31);
    bus_read(ADDR_CONFIG, rd);
    check("irq_set_wins", rd, 32'h31);
    stop_pwm("setwins");
    bus_read(ADDR_CONFIG, rd);
    check("irq_cleared_cfg", rd, 32'h0);

    // IRQ clear with a long period, then async reset mid-period
    start_pwm(0, 100, 50, 0, 0, 0, 1'b1, t0);
    repeat (110) @(posedge clk);
    @(negedge clk);
    check("irq_at_wrap", 32'(pwm_irq), 32'h1);
    bus_write(ADDR_CONFIG, 4'hF, 32'h31);
    @(negedge clk);
    check("irq_write_clear", 32'(pwm_irq), 32'h0);
    bus_read(ADDR_TOP, rd);
    check("pre_reset_top", rd, 32'd100);
    @(negedge clk);
    check("pre_reset_pwm1", 32'(pwm_out[1]), 32'h1);
    #5 rst_n = 1'b0;
    #1;
    check("async_reset_pwm", 32'(pwm_out), 32'h0);
    check("async_reset_irq", 32'(pwm_irq), 32'h0);
    check("async_reset_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post_reset_pwm", 32'(pwm_out), 32'h0);
    bus_read(ADDR_CONFIG, rd);
    check("post_reset_cfg", rd, 32'h0);
    bus_read(ADDR_TOP, rd);
    check("post_reset_top", rd, 32'h0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
